// File: rtl/dat_mem_pingpong_ctrl.sv
// dat_mem_pingpong_ctrl
// Sequences two external single-port burst RAMs as a ping-pong pair between
// the conv-engine result stream (fill side) and an AXI write-back burst
// (drain side). One bank is filled while the other is streamed out.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   in_valid/in_ready/in_data   fill beat handshake and payload
//   in_last                     closes the current burst early
//   mem_wr_en/mem_waddr/mem_wdata  per-bank write enables, shared addr/data
//   mem_rd_en/mem_raddr         per-bank read enables, shared read address
//   mem_rdata0/mem_rdata1       bank read data (1-cycle latency, held)
//   aw_valid/aw_ready/aw_len    burst request (aw_len = beats - 1)
//   m_valid/m_ready/m_data/m_last  drain beat stream
//   busy                        a bank is full or a partial fill is pending
module dat_mem_pingpong_ctrl #(
  parameter int unsigned BURST_LEN = 16,
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic [1:0]        mem_wr_en,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [1:0]        mem_rd_en,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata0,
  input  logic [DATA_W-1:0] mem_rdata1,
  output logic              aw_valid,
  input  logic              aw_ready,
  output logic [ADDR_W-1:0] aw_len,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy
);

  // Read pointer runs one past the last beat, so it needs an extra bit.
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    D_IDLE,
    D_AW,
    D_STREAM
  } drain_state_t;

  drain_state_t      state_q, state_d;
  logic [1:0]        full_q;
  logic [ADDR_W-1:0] len_q [2];
  logic              wbank_q;
  logic [ADDR_W-1:0] wcnt_q;
  logic              rbank_q;
  logic [CNT_W-1:0]  raddr_q, raddr_d;
  logic [ADDR_W-1:0] beats_q, beats_d;
  logic              m_valid_q, m_valid_d;

  logic              in_hs;
  logic              fill_close;
  logic              rd_issue;
  logic              drain_done;
  logic [ADDR_W-1:0] len_r;

  // Fill side: the write goes to the RAM on the handshake edge itself.
  assign in_ready   = rst_n && !full_q[wbank_q];
  assign in_hs      = in_valid && in_ready;
  assign fill_close = in_hs && ((wcnt_q == ADDR_W'(BURST_LEN - 1)) || in_last);
  assign mem_wr_en  = {in_hs && wbank_q, in_hs && !wbank_q};
  assign mem_waddr  = in_hs ? wcnt_q : '0;
  assign mem_wdata  = rst_n ? in_data : '0;

  // Drain side datapath.
  assign len_r     = len_q[rbank_q];
  assign m_valid   = m_valid_q;
  assign m_last    = m_valid_q && (beats_q == len_r);
  assign m_data    = m_valid_q ? (rbank_q ? mem_rdata1 : mem_rdata0) : '0;
  assign mem_rd_en = {rd_issue && rbank_q, rd_issue && !rbank_q};
  assign mem_raddr = rd_issue ? raddr_q[ADDR_W-1:0] : '0;
  assign busy      = (|full_q) || (wcnt_q != '0);

  // Drain FSM next-state and outputs.
  always_comb begin
    state_d    = state_q;
    raddr_d    = raddr_q;
    beats_d    = beats_q;
    m_valid_d  = m_valid_q;
    rd_issue   = 1'b0;
    drain_done = 1'b0;
    aw_valid   = 1'b0;
    aw_len     = '0;
    case (state_q)
      D_IDLE: begin
        if (full_q[rbank_q]) state_d = D_AW;
      end
      D_AW: begin
        aw_valid = 1'b1;
        aw_len   = len_r;
        if (aw_ready) begin
          state_d = D_STREAM;
          raddr_d = '0;
          beats_d = '0;
        end
      end
      D_STREAM: begin
        // Only fetch when the output register is free or being emptied,
        // so held RAM data keeps m_data stable under backpressure.
        rd_issue = (raddr_q <= {1'b0, len_r}) && (!m_valid_q || m_ready);
        if (rd_issue) begin
          raddr_d   = raddr_q + CNT_W'(1);
          m_valid_d = 1'b1;
        end else if (m_valid_q && m_ready) begin
          m_valid_d = 1'b0;
        end
        if (m_valid_q && m_ready) begin
          beats_d = beats_q + ADDR_W'(1);
          if (m_last) begin
            drain_done = 1'b1;
            state_d    = D_IDLE;
          end
        end
      end
      default: state_d = D_IDLE;
    endcase
  end

  // State and bookkeeping registers. A closing fill and a finishing drain
  // always target different banks, so both full bits can update together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= D_IDLE;
      full_q    <= '0;
      len_q[0]  <= '0;
      len_q[1]  <= '0;
      wbank_q   <= 1'b0;
      wcnt_q    <= '0;
      rbank_q   <= 1'b0;
      raddr_q   <= '0;
      beats_q   <= '0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      raddr_q   <= raddr_d;
      beats_q   <= beats_d;
      m_valid_q <= m_valid_d;
      if (fill_close) begin
        full_q[wbank_q] <= 1'b1;
        len_q[wbank_q]  <= wcnt_q;
        wcnt_q          <= '0;
        wbank_q         <= ~wbank_q;
      end else if (in_hs) begin
        wcnt_q <= wcnt_q + ADDR_W'(1);
      end
      if (drain_done) begin
        full_q[rbank_q] <= 1'b0;
        rbank_q         <= ~rbank_q;
      end
    end
  end

endmodule

// File: tb/tb_dat_mem_pingpong_ctrl.sv
// Scoreboard bench for dat_mem_pingpong_ctrl: the driver pushes expected
// drain beats and burst lengths; a negedge monitor pops and compares.
module tb_dat_mem_pingpong_ctrl;
  localparam int unsigned BL = 16;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic [1:0]    mem_wr_en;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [1:0]    mem_rd_en;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata0;
  logic [DW-1:0] mem_rdata1;
  logic          aw_valid;
  logic          aw_ready;
  logic [AW-1:0] aw_len;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;

  dat_mem_pingpong_ctrl #(.BURST_LEN(BL), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .mem_wr_en(mem_wr_en), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_rd_en(mem_rd_en), .mem_raddr(mem_raddr),
    .mem_rdata0(mem_rdata0), .mem_rdata1(mem_rdata1),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_len(aw_len),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank RAM models: 1-cycle read latency, data held while rd_en is low.
  logic [DW-1:0] ram0 [BL];
  logic [DW-1:0] ram1 [BL];
  initial begin
    mem_rdata0 = '0;
    mem_rdata1 = '0;
  end
  always @(posedge clk) begin
    if (mem_wr_en[0]) ram0[mem_waddr] <= mem_wdata;
    if (mem_wr_en[1]) ram1[mem_waddr] <= mem_wdata;
    if (mem_rd_en[0]) mem_rdata0 <= ram0[mem_raddr];
    if (mem_rd_en[1]) mem_rdata1 <= ram1[mem_raddr];
  end

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_data [$];
  bit            exp_last [$];
  logic [AW-1:0] exp_len  [$];
  int  out_cnt   = 0;
  int  stall_pct = 0;
  bit  mb = 1'b0;   // model fill bank
  int  mc = 0;      // model fill pointer
  bit  prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic [DW-1:0] mon_d;
  bit            mon_l;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one fill beat; checks the write port against the bank model.
  task automatic put(input logic [DW-1:0] d, input bit last);
    int n;
    bit close;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      return;
    end
    chk("wr_en", 32'(mem_wr_en), mb ? 32'd2 : 32'd1);
    chk("waddr", 32'(mem_waddr), 32'(mc));
    chk("wdata", mem_wdata, d);
    close = (mc == int'(BL) - 1) || last;
    exp_data.push_back(d);
    exp_last.push_back(close);
    if (close) begin
      exp_len.push_back(AW'(mc));
      mb = ~mb;
      mc = 0;
    end else begin
      mc++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_data.size() != 0 || exp_len.size() != 0 || m_valid) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", 32'(exp_data.size()), 32'd0);
    @(negedge clk);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Monitor: burst requests, drain beats, stall stability.
  always @(negedge clk) begin
    if (rst_n) begin
      if (aw_valid && aw_ready) begin
        if (exp_len.size() == 0) chk("aw_unexpected", 32'd1, 32'd0);
        else chk("aw_len", 32'(aw_len), 32'(exp_len.pop_front()));
      end
      if (prev_stall) begin
        chk("m_valid_hold", 32'(m_valid), 32'd1);
        chk("m_data_stable", m_data, prev_data);
      end
      if (m_valid && !m_ready) begin
        chk("rd_en_in_stall", 32'(mem_rd_en), 32'd0);
        prev_stall = 1'b1;
        prev_data  = m_data;
      end else begin
        prev_stall = 1'b0;
      end
      if (m_valid && m_ready) begin
        if (exp_data.size() == 0) begin
          chk("beat_unexpected", 32'd1, 32'd0);
        end else begin
          mon_d = exp_data.pop_front();
          mon_l = exp_last.pop_front();
          chk("m_data", m_data, mon_d);
          chk("m_last", 32'(m_last), 32'(mon_l));
          out_cnt++;
        end
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Downstream ready: held high unless a stall percentage is set.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = (stall_pct == 0) ? 1'b1 : (int'($urandom_range(0, 99)) >= stall_pct);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    aw_ready = 1'b0;

    // Reset: in_ready low while reset is held, everything quiet after.
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_aw_valid", 32'(aw_valid), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_wr_en", 32'(mem_wr_en), 32'd0);
    @(posedge clk); #1;

    // Single full burst 0x00..0x0F.
    aw_ready = 1'b1;
    for (int i = 0; i < 16; i++) put(32'(i), 1'b0);
    wait_drain(200);

    // Partial burst of 5, closed by in_last; lands in bank 1.
    for (int i = 0; i < 5; i++) put(32'h50 + 32'(i), i == 4);
    wait_drain(200);

    // Ping-pong stall: both banks fill, then refill resumes after drain.
    aw_ready = 1'b0;
    for (int i = 1; i <= 32; i++) put(32'h100 + 32'(i), 1'b0);
    @(negedge clk);
    chk("both_full_in_ready", 32'(in_ready), 32'd0);
    chk("stall_aw_valid", 32'(aw_valid), 32'd1);
    chk("stall_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    fork
      begin
        for (int i = 33; i <= 40; i++) put(32'h100 + 32'(i), i == 40);
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        aw_ready = 1'b1;
      end
    join
    wait_drain(400);

    // Random backpressure across 64 beats.
    stall_pct = 30;
    for (int i = 0; i < 64; i++) put(32'h200 + 32'(i), 1'b0);
    wait_drain(2000);
    stall_pct = 0;
    @(posedge clk); #1;

    // Reset in the middle of a drain.
    out_cnt = 0;
    for (int i = 0; i < 16; i++) put(32'h300 + 32'(i), 1'b0);
    n = 0;
    while (out_cnt < 7 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mid_drain_reached", 32'(out_cnt >= 7), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_data.delete();
    exp_last.delete();
    exp_len.delete();
    mb = 1'b0;
    mc = 0;
    @(negedge clk);
    chk("rst2_m_valid", 32'(m_valid), 32'd0);
    chk("rst2_m_last", 32'(m_last), 32'd0);
    chk("rst2_aw_valid", 32'(aw_valid), 32'd0);
    chk("rst2_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst2_in_ready", 32'(in_ready), 32'd1);
    chk("rst2_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) put(32'h400 + 32'(i), 1'b0);
    wait_drain(200);

    // 1-beat burst.
    put(32'hABCD, 1'b1);
    wait_drain(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dat_mem_pingpong_ctrl.md
# dat_mem_pingpong_ctrl

Ping-pong controller that sequences two `dat_mem_1bit` burst buffers between the conv-engine output stream and the AXI write-back path. The fill side packs `Tout`-wide result beats into one bank while the drain side streams the other bank out as a single AXI burst. Partial bursts are closed early on `in_last`. The block owns all bank addressing, bank selection and burst-length bookkeeping; the banks themselves stay plain RAMs instantiated beside it.

## Interface
- `BURST_LEN`, default `AXI_BURST_LEN` (16): beats per bank; power of two.
- `ADDR_W`, default `log2AXI_BURST_LEN` (4): bank address width.
- `DATA_W`, default `Tout` (32): beat width.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: fill beat valid.
- `in_ready` out 1: fill beat accepted when `in_valid && in_ready`.
- `in_data` in DATA_W: fill beat.
- `in_last` in 1: beat closes the current burst; qualified by the handshake.
- `mem_wr_en` out 2: per-bank write enable; bit b drives bank b.
- `mem_waddr` out ADDR_W: shared write address.
- `mem_wdata` out DATA_W: shared write data, equal to `in_data`.
- `mem_rd_en` out 2: per-bank read enable.
- `mem_raddr` out ADDR_W: shared read address.
- `mem_rdata0` in DATA_W: bank 0 read data; 1-cycle latency, holds while `rd_en` is low.
- `mem_rdata1` in DATA_W: bank 1 read data; same behaviour.
- `aw_valid` out 1: burst request valid.
- `aw_ready` in 1: burst request accepted.
- `aw_len` out ADDR_W: beats minus 1.
- `m_valid` out 1: drain beat valid.
- `m_ready` in 1: drain beat accepted.
- `m_data` out DATA_W: drain beat.
- `m_last` out 1: final beat of the burst.
- `busy` out 1: any bank full or any fill beat pending.

## Operation
- **State**
  - `full[1:0]`: bank holds a closed burst.
  - `len0`, `len1`: ADDR_W bits each, stored beats-1.
  - `wbank`, `wcnt`: fill bank and fill pointer.
  - `rbank`, `raddr_cnt`: drain bank and read pointer.
  - `beats_out`: count of handshaked drain beats.
- **Fill**
  - `in_ready = rst_n && !full[wbank]`.
  - On handshake: `mem_wr_en[wbank]=1`, `mem_waddr=wcnt`, `wcnt++`.
  - A burst closes when `wcnt==BURST_LEN-1` or `in_last` on the handshake. On close:
    - set `full[wbank]`;
    - set `len[wbank]=wcnt`;
    - clear `wcnt`;
    - toggle `wbank`.
  - `mem_wr_en` is zero whenever there is no handshake.
- **Drain FSM**
  - `D_IDLE`: move to `D_AW` when `full[rbank]`.
  - `D_AW`: `aw_valid=1`, `aw_len=len[rbank]`; move to `D_STREAM` on `aw_ready`; clear `raddr_cnt` and `beats_out`.
  - `D_STREAM`:
    - Issue read (`mem_rd_en[rbank]=1`, `mem_raddr=raddr_cnt`, `raddr_cnt++`) when `raddr_cnt<=len[rbank]` and (`!m_valid || m_ready`).
    - `m_valid` is registered: it is set the cycle after an issued read and cleared on a handshake with no new read issued.
    - `m_data` is the `mem_rdata` of `rbank`.
    - `m_last = m_valid && beats_out==len[rbank]`.
    - On `m_valid && m_ready && m_last`: clear `full[rbank]`, toggle `rbank`, return to `D_IDLE`.
- **Output values**
  - `aw_valid` is 0 outside `D_AW`.
  - `aw_len` is 0 outside `D_AW`.
  - `mem_rd_en` is 0 outside `D_STREAM`.
- **Boundary conditions**
  - Both banks full: `in_ready=0`.
  - A bank freed on cycle N is fillable from N+1; there is no same-cycle bypass.
  - Close and drain-start of the same bank never coincide, because drain sees `full` one cycle after it is set.
  - `in_last` on the BURST_LEN-th beat is a single close, not two.
  - A 1-beat burst is legal: `aw_len=0`, `m_last` on the first beat.
  - `in_last` with no handshake is ignored.
- **Reset**
  - Synchronous and active-low.
  - Clears: all counters, `full`, `len0`, `len1`, `wbank=0`, `rbank=0`, FSM to `D_IDLE`.
  - All outputs are 0, including `in_ready`, which is 0 while `rst_n` is low.
  - Reset mid-burst discards the partial fill and any in-flight drain without completing it.

## Timing
- **Fill**: the write reaches the RAM on the same edge as the handshake; zero added latency.
- **Close to `aw_valid`**: `full` is set at edge N, drain enters `D_AW` at N+1, so `aw_valid` is high in cycle N+1.
- **`aw_ready` to first beat**: the read is issued in the first `D_STREAM` cycle and `m_valid` is high one cycle later, i.e. 2 cycles after the `aw_ready` cycle.
- **Throughput**: with `m_ready` held high, one beat per cycle, back-to-back.
- **Bank switch overhead**: `D_IDLE`→`D_AW` costs 1 cycle, plus the `aw` handshake, plus 1 read-latency cycle.
- **Backpressure**: while `m_ready=0` no read is issued and the RAM holds `rdata`, so `m_data` stays stable.

## Test plan
- **Single full burst**: BURST_LEN=16; 16 beats `0x00..0x0F`, `aw_ready=1`, `m_ready=1`.
  - `aw_len=15`.
  - `m_data` is `0x00..0x0F` in order, one per cycle.
  - `m_last` is high only on `0x0F`.
  - `full` returns to 0.
- **Partial burst**: 5 beats with `in_last` on the 5th.
  - `aw_len=4`, 5 output beats, `m_last` on beat 5.
  - The next fill goes to bank 1 at address 0.
- **Ping-pong stall**: 40 beats continuous, `aw_ready=0`.
  - `in_ready` drops after beat 32.
  - Releasing `aw_ready` drains bank 0, then refill resumes into bank 0 at beat 33.
- **Random `m_ready`**: 30% stall on `m_ready` across 64 beats.
  - Output sequence is lossless and in order.
  - `m_data` is stable for every stalled cycle.
  - `mem_rd_en` is never high when `m_valid && !m_ready`.
- **Reset mid-drain**: assert `rst_n=0` for 1 cycle at beat 7 of a drain.
  - Next cycle: all outputs 0, `in_ready=1`, both banks empty.
  - A fresh 16-beat burst drains correctly from bank 0.
- **1-beat burst**: a single beat with `in_last`.
  - `aw_len=0`; one output beat with `m_valid` and `m_last` both high.
